// File: rtl/vga_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vga_pkg: shared scheduler state, defaults and pattern encoding.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package vga_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN,
    PAUSED
  } sched_state_t;

  localparam int VGA_NUM_PATTERNS = 8;
  localparam int VGA_HOLD_FRAMES  = 60;
  localparam int VGA_PAT_W        = 3;

  // Index values understood by the colour-pattern generator.
  typedef enum logic [VGA_PAT_W-1:0] {
    PAT_BARS   = 3'd0,
    PAT_GRAY   = 3'd1,
    PAT_CHECK  = 3'd2,
    PAT_GRID   = 3'd3,
    PAT_RED    = 3'd4,
    PAT_GREEN  = 3'd5,
    PAT_BLUE   = 3'd6,
    PAT_WHITE  = 3'd7
  } vga_pattern_t;

endpackage
`default_nettype wire

// File: rtl/vga_frame_edge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vga_frame_edge: rising-edge detector on the timing frame_start.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module vga_frame_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_start_i,
  output logic fs_rise_o
);

  logic fs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fs_q <= 1'b0;
    end else begin
      fs_q <= frame_start_i;
    end
  end

  assign fs_rise_o = frame_start_i & ~fs_q;

endmodule
`default_nettype wire

// File: rtl/vga_pattern_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vga_pattern_sched: frame-synchronous pattern scheduler with pause, |
// | single-step; VGA_SCHED_PINGPONG_EN selects up/down sequencing.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module vga_pattern_sched
  import vga_pkg::*;
#(
  parameter  int NUM_PATTERNS = VGA_NUM_PATTERNS,
  parameter  int PAT_W        = VGA_PAT_W,
  parameter  int HOLD_FRAMES  = VGA_HOLD_FRAMES,
  localparam int CNT_W        = $clog2(HOLD_FRAMES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_i,
  input  logic             frame_start_i,
  input  logic             pause_i,
  input  logic             step_req_i,
  output logic [PAT_W-1:0] pattern_sel_o,
  output logic             pattern_valid_o,
  output logic [CNT_W-1:0] frame_cnt_o,
  output logic             wrap_pulse_o
);

  localparam logic [PAT_W-1:0] PAT_LAST  = PAT_W'(NUM_PATTERNS - 1);
  localparam logic [PAT_W-1:0] PAT_FIRST = PAT_W'(PAT_BARS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(HOLD_FRAMES - 1);

  logic fs_rise;

  vga_frame_edge u_frame_edge (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_start_i (frame_start_i),
    .fs_rise_o     (fs_rise)
  );

  sched_state_t     state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             step_q, step_d;
  logic             adv;
`ifdef VGA_SCHED_PINGPONG_EN
  logic             down_q, down_d;
`endif

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    step_d  = step_q;
    adv     = 1'b0;
`ifdef VGA_SCHED_PINGPONG_EN
    down_d  = down_q;
`endif

    if (!enable_i) begin
      state_d = IDLE;
      pat_d   = PAT_FIRST;
      valid_d = 1'b0;
      cnt_d   = '0;
      step_d  = 1'b0;
`ifdef VGA_SCHED_PINGPONG_EN
      down_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: state_d = ARM;
        ARM: begin
          if (fs_rise) begin
            state_d = RUN;
            pat_d   = PAT_FIRST;
            valid_d = 1'b1;
            cnt_d   = '0;
          end
        end
        RUN: begin
          // A pause seen together with a frame edge suppresses the count.
          if (pause_i) begin
            state_d = PAUSED;
          end else if (fs_rise) begin
            if (cnt_q == CNT_LAST) begin
              cnt_d = '0;
              adv   = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        PAUSED: begin
          if (!pause_i) begin
            state_d = RUN;
            step_d  = 1'b0;
          end else if (fs_rise && (step_q || step_req_i)) begin
            cnt_d  = '0;
            step_d = 1'b0;
            adv    = 1'b1;
          end else if (step_req_i) begin
            step_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (adv) begin
`ifdef VGA_SCHED_PINGPONG_EN
      if (!down_q) begin
        pat_d = pat_q + PAT_W'(1);
        if (pat_d == PAT_LAST) begin
          down_d = 1'b1;
          wrap_d = 1'b1;
        end
      end else begin
        pat_d = pat_q - PAT_W'(1);
        if (pat_d == PAT_FIRST) begin
          down_d = 1'b0;
          wrap_d = 1'b1;
        end
      end
`else
      if (pat_q == PAT_LAST) begin
        pat_d  = PAT_FIRST;
        wrap_d = 1'b1;
      end else begin
        pat_d = pat_q + PAT_W'(1);
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pat_q   <= PAT_FIRST;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      step_q  <= 1'b0;
`ifdef VGA_SCHED_PINGPONG_EN
      down_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      step_q  <= step_d;
`ifdef VGA_SCHED_PINGPONG_EN
      down_q  <= down_d;
`endif
    end
  end

  assign pattern_sel_o   = pat_q;
  assign pattern_valid_o = valid_q;
  assign frame_cnt_o     = cnt_q;
  assign wrap_pulse_o    = wrap_q;

endmodule
`default_nettype wire
